// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cnn_pkg : lane/accumulator widths and systolic_feeder state encoding        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package cnn_pkg;

    localparam int LANE_W = 8;
    localparam int MAC_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/skew_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skew_lane : picks buffer[t-LANE] for one lane, or 0 outside 0 <= t-LANE < k |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module skew_lane
    import cnn_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int T_W   = 4,
    parameter int K_W   = 4,
    parameter int LANE  = 0
) (
    input  logic [DEPTH*LANE_W-1:0] column,
    input  logic [T_W-1:0]          t,
    input  logic [K_W-1:0]          k,
    output logic [LANE_W-1:0]       lane
);

    logic [T_W-1:0] idx;

    always_comb begin
        idx  = t - T_W'(LANE);
        lane = '0;
        if ((t >= T_W'(LANE)) && (idx < T_W'(k))) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (idx == T_W'(e)) begin
                    lane = column[e*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_feeder : buffers K operand vectors and streams them diagonally     |
// | skewed into an output-accumulating systolic array.                          |
// | Option: SYSTOLIC_FEEDER_CNT_EN adds the 16-bit cycle_cnt output.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module systolic_feeder
    import cnn_pkg::*;
#(
    parameter int array_size = 3,
    parameter int k_depth    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [array_size*LANE_W-1:0] in_data,
    input  logic [array_size*LANE_W-1:0] in_weight,
    input  logic                         in_last,
    output logic                         arr_clear,
    output logic [array_size*LANE_W-1:0] datain,
    output logic [array_size*LANE_W-1:0] weightin,
    output logic                         busy,
    output logic                         done
`ifdef SYSTOLIC_FEEDER_CNT_EN
    ,
    output logic [15:0]                  cycle_cnt
`endif
);

    localparam int K_W = $clog2(k_depth + 1);
    localparam int T_W = $clog2(k_depth + array_size + 1);
    localparam int V_W = array_size * LANE_W;

    feeder_state_t  state;
    logic [K_W-1:0] k_cnt;
    logic [T_W-1:0] t;
    logic [T_W-1:0] t_sel;
    logic [K_W-1:0] wr_idx;
    logic           accept;
    logic           to_clear;
    logic [V_W-1:0] sel_data;
    logic [V_W-1:0] sel_weight;
    logic [V_W-1:0] buf_data   [k_depth];
    logic [V_W-1:0] buf_weight [k_depth];

    assign accept   = in_valid && in_ready;
    assign to_clear = accept && (in_last || (k_depth == 1) ||
                      ((state == ST_LOAD) && (k_cnt == K_W'(k_depth - 1))));
    assign wr_idx   = (state == ST_IDLE) ? '0 : k_cnt;
    // Lane registers are loaded one cycle ahead, so the mux looks at the next t.
    assign t_sel    = (state == ST_CLEAR) ? '0 : t + T_W'(1);

    // Buffer has no reset: contents are don't-care until rewritten by a job.
    always_ff @(posedge clk) begin
        for (int e = 0; e < k_depth; e++) begin
            if (accept && (wr_idx == K_W'(e))) begin
                buf_data[e]   <= in_data;
                buf_weight[e] <= in_weight;
            end
        end
    end

    for (genvar i = 0; i < array_size; i++) begin : g_lane
        logic [k_depth*LANE_W-1:0] dcol;
        logic [k_depth*LANE_W-1:0] wcol;

        always_comb begin
            dcol = '0;
            wcol = '0;
            for (int e = 0; e < k_depth; e++) begin
                dcol[e*LANE_W +: LANE_W] = buf_data[e][i*LANE_W +: LANE_W];
                wcol[e*LANE_W +: LANE_W] = buf_weight[e][i*LANE_W +: LANE_W];
            end
        end

        skew_lane #(.DEPTH(k_depth), .T_W(T_W), .K_W(K_W), .LANE(i)) u_data (
            .column (dcol),
            .t      (t_sel),
            .k      (k_cnt),
            .lane   (sel_data[i*LANE_W +: LANE_W])
        );

        skew_lane #(.DEPTH(k_depth), .T_W(T_W), .K_W(K_W), .LANE(i)) u_weight (
            .column (wcol),
            .t      (t_sel),
            .k      (k_cnt),
            .lane   (sel_weight[i*LANE_W +: LANE_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            k_cnt     <= '0;
            t         <= '0;
            in_ready  <= 1'b0;
            arr_clear <= 1'b1;
            datain    <= '0;
            weightin  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            arr_clear <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        busy  <= 1'b1;
                        k_cnt <= (state == ST_IDLE) ? K_W'(1) : k_cnt + K_W'(1);
                        state <= ST_LOAD;
                        if (to_clear) begin
                            state     <= ST_CLEAR;
                            in_ready  <= 1'b0;
                            arr_clear <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    state    <= ST_STREAM;
                    t        <= '0;
                    datain   <= sel_data;
                    weightin <= sel_weight;
                end
                ST_STREAM: begin
                    if ((t + T_W'(1)) == (T_W'(k_cnt) + T_W'(array_size - 1))) begin
                        t        <= '0;
                        datain   <= '0;
                        weightin <= '0;
                        if (array_size == 1) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        t        <= t + T_W'(1);
                        datain   <= sel_data;
                        weightin <= sel_weight;
                    end
                end
                ST_DRAIN: begin
                    if ((t + T_W'(1)) == T_W'(array_size - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        t <= t + T_W'(1);
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    k_cnt    <= '0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SYSTOLIC_FEEDER_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (to_clear) begin
            cycle_cnt <= '0;
        end else if (((state == ST_CLEAR) || (state == ST_STREAM) || (state == ST_DRAIN))
                     && (cycle_cnt != 16'hFFFF)) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
